// File: rtl/pf_lanectrl_pause_sync_multi.sv
// Multi-lane clock-pause conditioner: resynchronise each lane's pause request, stretch it to a minimum
// width, enforce a minimum low gap between pauses, and record requests swallowed by that gap.

module pf_lanectrl_pause_lane #(
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 2,
  parameter int HOLDOFF_CYCLES   = 1
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CLR_STICKY,
  input  logic req,
  output logic pause,
  output logic drop
);
  localparam logic [3:0] MIN_LOAD  = 4'(MIN_PAUSE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD = (HOLDOFF_CYCLES == 0) ? 4'd0 : 4'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  (* syn_keep = 1 *) logic [SYNC_STAGES-1:0] sync_q;
  logic       s;
  state_t     state;
  logic [3:0] cnt;
  logic       seen;

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= SYNC_STAGES'({sync_q, req});

  assign s = sync_q[SYNC_STAGES-1];

  // pause is a registered decode of state==ACTIVE, updated alongside the state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
      seen  <= 1'b0;
      pause <= 1'b0;
      drop  <= 1'b0;
    end else begin
      if (CLR_STICKY) drop <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= ACTIVE;
            cnt   <= MIN_LOAD;
            pause <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
          else if (!s) begin
            pause <= 1'b0;
            if (HOLDOFF_CYCLES == 0) state <= IDLE;
            else begin
              state <= HOLD;
              cnt   <= HOLD_LOAD;
              seen  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (s) seen <= 1'b1;
          if (cnt != '0) cnt <= cnt - 4'd1;
          else if (s) begin
            state <= ACTIVE;
            cnt   <= MIN_LOAD;
            pause <= 1'b1;
          end else begin
            state <= IDLE;
            // a request came and went inside the gap: it never produced a pause
            if (seen) drop <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          pause <= 1'b0;
        end
      endcase
    end
  end
endmodule

module pf_lanectrl_pause_sync_multi #(
  parameter int NUM_LANES        = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 2,
  parameter int HOLDOFF_CYCLES   = 1,
  parameter int OUT_ON_FALL      = 0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 BYPASS,
  input  logic                 CLR_STICKY,
  input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
  output logic [NUM_LANES-1:0] PAUSE_ACTIVE,
  output logic [NUM_LANES-1:0] DROP_STICKY
);
  logic [NUM_LANES-1:0] pause_q;
  logic [NUM_LANES-1:0] pause_out;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pf_lanectrl_pause_lane #(
      .SYNC_STAGES      (SYNC_STAGES),
      .MIN_PAUSE_CYCLES (MIN_PAUSE_CYCLES),
      .HOLDOFF_CYCLES   (HOLDOFF_CYCLES)
    ) u_lane (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .CLR_STICKY (CLR_STICKY),
      .req        (HS_IO_CLK_PAUSE[i]),
      .pause      (pause_q[i]),
      .drop       (DROP_STICKY[i])
    );
  end

  if (OUT_ON_FALL != 0) begin : g_fall
    logic [NUM_LANES-1:0] fall_q;
    always_ff @(negedge CLK or negedge RESET_N)
      if (!RESET_N) fall_q <= '0;
      else          fall_q <= pause_q;
    assign pause_out = fall_q;
  end else begin : g_rise
    assign pause_out = pause_q;
  end

  // bypass is quasi-static; the FSMs keep tracking so PAUSE_ACTIVE stays meaningful
  assign HS_IO_CLK_PAUSE_SYNC = BYPASS ? HS_IO_CLK_PAUSE : pause_out;
  assign PAUSE_ACTIVE         = pause_q;
endmodule

// File: tb/tb_pf_lanectrl_pause_sync_multi.sv
// Directed bench: four instances (defaults, MIN=4, HOLDOFF=3, OUT_ON_FALL=1) share one stimulus bus.
module tb_pf_lanectrl_pause_sync_multi;
  logic       CLK = 1'b0;
  logic       RESET_N, BYPASS, CLR_STICKY;
  logic [3:0] req;
  logic [3:0] sync_d, act_d, drop_d, sync_m, act_m, drop_m;
  logic [3:0] sync_h, act_h, drop_h, sync_f, act_f, drop_f;

  always #5 CLK = ~CLK;

  pf_lanectrl_pause_sync_multi u_def (
    .CLK(CLK), .RESET_N(RESET_N), .BYPASS(BYPASS), .CLR_STICKY(CLR_STICKY),
    .HS_IO_CLK_PAUSE(req), .HS_IO_CLK_PAUSE_SYNC(sync_d), .PAUSE_ACTIVE(act_d), .DROP_STICKY(drop_d));
  pf_lanectrl_pause_sync_multi #(.MIN_PAUSE_CYCLES(4)) u_min4 (
    .CLK(CLK), .RESET_N(RESET_N), .BYPASS(BYPASS), .CLR_STICKY(CLR_STICKY),
    .HS_IO_CLK_PAUSE(req), .HS_IO_CLK_PAUSE_SYNC(sync_m), .PAUSE_ACTIVE(act_m), .DROP_STICKY(drop_m));
  pf_lanectrl_pause_sync_multi #(.HOLDOFF_CYCLES(3)) u_hold3 (
    .CLK(CLK), .RESET_N(RESET_N), .BYPASS(BYPASS), .CLR_STICKY(CLR_STICKY),
    .HS_IO_CLK_PAUSE(req), .HS_IO_CLK_PAUSE_SYNC(sync_h), .PAUSE_ACTIVE(act_h), .DROP_STICKY(drop_h));
  pf_lanectrl_pause_sync_multi #(.OUT_ON_FALL(1)) u_fall (
    .CLK(CLK), .RESET_N(RESET_N), .BYPASS(BYPASS), .CLR_STICKY(CLR_STICKY),
    .HS_IO_CLK_PAUSE(req), .HS_IO_CLK_PAUSE_SYNC(sync_f), .PAUSE_ACTIVE(act_f), .DROP_STICKY(drop_f));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    int          lane;
    logic [15:0] pat;
    int          dly;
    int          wid;
    int          rises;
    int          gap;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic get_out(input int inst, input int lane);
    case (inst)
      0:       return sync_d[lane];
      1:       return sync_m[lane];
      2:       return sync_h[lane];
      default: return sync_f[lane];
    endcase
  endfunction

  // pat[k] is the request level during posedge k; measurements are in ticks from the first drive
  task automatic run_pat(input int inst, input int lane, input logic [15:0] pat, input int clr_at,
                         output int delay, output int width, output int rises, output int gap);
    logic prev, o;
    int   fall_t;
    delay = -1; width = 0; rises = 0; gap = 0; prev = 1'b0; fall_t = -1;
    req[lane]  = pat[0];
    CLR_STICKY = (clr_at == 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      o = get_out(inst, lane);
      if (o && !prev) begin
        rises++;
        if (delay < 0) delay = k;
        else if (fall_t >= 0 && gap == 0) gap = k - fall_t;
      end
      if (!o && prev && fall_t < 0) fall_t = k;
      if (o) width++;
      prev = o;
      if (k < 16) req[lane] = pat[k];
      else        req[lane] = 1'b0;
      CLR_STICKY = (k == clr_at);
    end
    CLR_STICKY = 1'b0;
  endtask

  initial begin
    int d, w, r, g;
    logic [3:0] byp_pats [5];

    vecs[0] = '{1, 0, 16'h0001, 3, 4,  1, 0};  // 1-cycle pulse stretched to MIN=4
    vecs[1] = '{0, 1, 16'h03FF, 3, 10, 1, 0};  // long request passes through
    vecs[2] = '{1, 0, 16'h0007, 3, 4,  1, 0};
    vecs[3] = '{1, 0, 16'h003F, 3, 6,  1, 0};
    vecs[4] = '{1, 0, 16'h0005, 3, 4,  1, 0};  // fall/re-rise inside the stretch merges
    vecs[5] = '{0, 0, 16'h0005, 3, 3,  1, 0};
    vecs[6] = '{0, 0, 16'h0011, 3, 4,  2, 2};
    vecs[7] = '{0, 0, 16'h0001, 3, 2,  1, 0};
    vecs[8] = '{3, 2, 16'h000F, 3, 4,  1, 0};
    vecs[9] = '{2, 3, 16'h0001, 3, 2,  1, 0};
    byp_pats = '{4'h1, 4'h6, 4'hF, 4'h0, 4'hA};

    // reset with all requests high
    RESET_N = 1'b0; BYPASS = 1'b0; CLR_STICKY = 1'b0; req = 4'hF;
    repeat (3) tick();
    check("reset_sync_def", sync_d, 4'h0);
    check("reset_act_def", act_d, 4'h0);
    check("reset_drop_hold3", drop_h, 4'h0);
    check("reset_sync_fall", sync_f, 4'h0);
    RESET_N = 1'b1;
    tick(); tick();
    check("release_tick2", sync_d, 4'h0);
    tick();
    check("release_tick3_sync", sync_d, 4'hF);
    check("release_tick3_act", act_d, 4'hF);
    req = 4'h0;
    repeat (40) tick();

    for (int i = 0; i < 10; i++) begin
      run_pat(vecs[i].inst, vecs[i].lane, vecs[i].pat, -1, d, w, r, g);
      check($sformatf("vec%0d_delay", i), d, vecs[i].dly);
      check($sformatf("vec%0d_width", i), w, vecs[i].wid);
      check($sformatf("vec%0d_rises", i), r, vecs[i].rises);
      check($sformatf("vec%0d_gap", i), g, vecs[i].gap);
    end

    // request lost in HOLD sets the sticky bit; no second pause
    check("drop_before", drop_h[2], 1'b0);
    run_pat(2, 2, 16'h0009, -1, d, w, r, g);
    check("drop_rises", r, 1);
    check("drop_width", w, 2);
    check("drop_set", drop_h[2], 1'b1);
    CLR_STICKY = 1'b1;
    tick();
    CLR_STICKY = 1'b0;
    check("drop_cleared", drop_h[2], 1'b0);
    run_pat(2, 2, 16'h0009, 7, d, w, r, g);
    check("drop_set_beats_clr", drop_h[2], 1'b1);
    run_pat(2, 2, 16'h0009, 12, d, w, r, g);
    check("drop_clr_after_set", drop_h[2], 1'b0);

    // re-request held through HOLD: deferred pause after exactly 3 low cycles
    run_pat(2, 3, 16'h01F9, -1, d, w, r, g);
    check("defer_delay", d, 3);
    check("defer_rises", r, 2);
    check("defer_gap", g, 3);
    check("defer_width", w, 6);
    check("defer_no_drop", drop_h[3], 1'b0);

    // negedge output stage trails the posedge FSM by half a cycle
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check("fall_act_rise", act_f[0], 1'b1);
    check("fall_out_still_low", sync_f[0], 1'b0);
    @(negedge CLK); #1;
    check("fall_out_rise", sync_f[0], 1'b1);
    @(posedge CLK); @(posedge CLK); #1;
    check("fall_act_fall", act_f[0], 1'b0);
    check("fall_out_still_high", sync_f[0], 1'b1);
    @(negedge CLK); #1;
    check("fall_out_fall", sync_f[0], 1'b0);
    repeat (20) tick();

    // bypass: output is the input with no clock, FSMs still tracking
    BYPASS = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req = byp_pats[i];
      #1;
      check($sformatf("byp%0d_def", i), sync_d, byp_pats[i]);
      check($sformatf("byp%0d_fall", i), sync_f, byp_pats[i]);
      repeat (4) tick();
      check($sformatf("byp%0d_act", i), act_d, byp_pats[i]);
    end
    req = 4'h0;
    repeat (10) tick();
    BYPASS = 1'b0;
    #1;
    check("byp_off", sync_d, 4'h0);

    // reset mid-pause drops everything without a clock edge
    tick();
    req[1] = 1'b1;
    repeat (5) tick();
    check("midpause_high", sync_d[1], 1'b1);
    check("midpause_fall_high", sync_f[1], 1'b1);
    RESET_N = 1'b0;
    #1;
    check("midreset_sync_def", sync_d, 4'h0);
    check("midreset_act_def", act_d, 4'h0);
    check("midreset_sync_fall", sync_f, 4'h0);
    check("midreset_drop_hold3", drop_h, 4'h0);
    req = 4'h0;
    tick();
    RESET_N = 1'b1;
    repeat (5) tick();
    check("post_reset_idle", sync_d, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
